// File: rtl/button_event.sv
// button_event: turns one debounced button level into single-cycle UI events
// (press, release, short click, long press, auto-repeat) plus a held level.
// All hold durations are counted in tick_fast periods.
// Optional feature macro: BUTTON_EVENT_REPEAT_EN enables auto-repeat while
// long-held. When it is undefined, repeat_pulse stays 0 and the counter holds
// in the long-held state.
module button_event #(
    parameter int LONG_TICKS   = 100,
    parameter int REPEAT_TICKS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_fast,
    input  logic btn_deb,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam int MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHORT = 2'd1,
        ST_LONG  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             btn_q_r;
    logic             press_r, press_s;
    logic             release_r, release_s;
    logic             short_r, short_s;
    logic             long_r, long_s;
    logic             repeat_r, repeat_s;
    logic             held_r, held_s;

    // Next-state, counter and next-output decode; release wins over a coincident tick.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        press_s   = 1'b0;
        release_s = 1'b0;
        short_s   = 1'b0;
        long_s    = 1'b0;
        repeat_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A press is a rising edge seen while idle; a tick in the
                // acceptance cycle is deliberately not counted.
                if (btn_deb && !btn_q_r) begin
                    press_s = 1'b1;
                    cnt_s   = CNT_ZERO;
                    state_s = ST_SHORT;
                end else begin
                    cnt_s   = CNT_ZERO;
                end
            end
            ST_SHORT: begin
                if (!btn_deb) begin
                    release_s = 1'b1;
                    short_s   = 1'b1;
                    cnt_s     = CNT_ZERO;
                    state_s   = ST_IDLE;
                end else if (tick_fast) begin
                    if (cnt_r == LONG_LAST) begin
                        long_s  = 1'b1;
                        cnt_s   = CNT_ZERO;
                        state_s = ST_LONG;
                    end else begin
                        cnt_s   = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_LONG: begin
                if (!btn_deb) begin
                    release_s = 1'b1;
                    cnt_s     = CNT_ZERO;
                    state_s   = ST_IDLE;
                end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
                    if (tick_fast) begin
                        if (cnt_r == REPEAT_LAST) begin
                            repeat_s = 1'b1;
                            cnt_s    = CNT_ZERO;
                        end else begin
                            cnt_s    = cnt_r + CNT_ONE;
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
`else
                    cnt_s = cnt_r;
`endif
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
        held_s = (state_s != ST_IDLE);
    end

    // State, counter, input sample and registered outputs; btn_q resets high
    // so a button held through reset is not taken as a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            btn_q_r   <= 1'b1;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            short_r   <= 1'b0;
            long_r    <= 1'b0;
            repeat_r  <= 1'b0;
            held_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            btn_q_r   <= btn_deb;
            press_r   <= press_s;
            release_r <= release_s;
            short_r   <= short_s;
            long_r    <= long_s;
            repeat_r  <= repeat_s;
            held_r    <= held_s;
        end
    end

    assign press_pulse   = press_r;
    assign release_pulse = release_r;
    assign short_pulse   = short_r;
    assign long_pulse    = long_r;
    assign repeat_pulse  = repeat_r;
    assign held          = held_r;

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with LONG_TICKS=5, REPEAT_TICKS=3 and
// tick_fast on every 4th clock. Expected cycle numbers are hand-computed
// from the start of each scenario (cycle 0 = first cycle with btn_deb=1).
module tb_button_event;

    logic clk = 1'b0;
    logic rst;
    logic tick_fast;
    logic btn_deb;
    logic press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held;

    int cyc;
    int n_cmp;
    int n_err;
    int held_n;
    int press_q[$];
    int release_q[$];
    int short_q[$];
    int long_q[$];
    int repeat_q[$];

    button_event #(
        .LONG_TICKS   (5),
        .REPEAT_TICKS (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick_fast     (tick_fast),
        .btn_deb       (btn_deb),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_pulse   (short_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .held          (held)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply inputs, take one clock, then log the registered outputs.
    task automatic step(input logic b, input logic r);
        btn_deb   = b;
        rst       = r;
        tick_fast = ((cyc % 4) == 3);
        @(posedge clk);
        #1;
        if (press_pulse)   press_q.push_back(cyc);
        if (release_pulse) release_q.push_back(cyc);
        if (short_pulse)   short_q.push_back(cyc);
        if (long_pulse)    long_q.push_back(cyc);
        if (repeat_pulse)  repeat_q.push_back(cyc);
        if (held)          held_n++;
        cyc++;
    endtask

    task automatic clear_log();
        cyc    = 0;
        held_n = 0;
        press_q.delete();
        release_q.delete();
        short_q.delete();
        long_q.delete();
        repeat_q.delete();
    endtask

    function automatic int outs();
        return int'({press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held});
    endfunction

    function automatic int first_of(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    task automatic reset_idle();
        cyc = 0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check_val("reset_outputs", outs(), 0);
        step(1'b0, 1'b0);
        clear_log();
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        btn_deb   = 1'b0;
        tick_fast = 1'b0;
        clear_log();

        // Short click: 10 clocks pressed (2 ticks), then release.
        reset_idle();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_val("click_rel_now", int'({release_pulse, short_pulse}), 3);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_val("click_press_n", press_q.size(), 1);
        check_val("click_press_at", first_of(press_q), 0);
        check_val("click_rel_at", first_of(release_q), 10);
        check_val("click_short_at", first_of(short_q), 10);
        check_val("click_long_n", long_q.size(), 0);
        check_val("click_held_n", held_n, 10);

        // Long hold: 48 clocks pressed, long at the 5th tick, repeats at 8th/11th.
        reset_idle();
        for (int i = 0; i < 48; i++) step(1'b1, 1'b0);
        check_val("long_held_lvl", int'(held), 1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_val("long_long_n", long_q.size(), 1);
        check_val("long_long_at", first_of(long_q), 19);
`ifdef BUTTON_EVENT_REPEAT_EN
        check_val("long_rep_n", repeat_q.size(), 2);
        check_val("long_rep0_at", first_of(repeat_q), 31);
        check_val("long_rep1_at", (repeat_q.size() > 1) ? repeat_q[1] : -1, 43);
`else
        check_val("long_rep_n", repeat_q.size(), 0);
`endif
        check_val("long_rel_at", first_of(release_q), 48);
        check_val("long_short_n", short_q.size(), 0);
        check_val("long_held_n", held_n, 48);

        // Release on the same cycle as the 5th tick: a click, not a long press.
        reset_idle();
        for (int i = 0; i < 19; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_val("coin_short_at", first_of(short_q), 19);
        check_val("coin_rel_at", first_of(release_q), 19);
        check_val("coin_long_n", long_q.size(), 0);

        // Button held through reset: no events until it is seen low then high.
        clear_log();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        check_val("hold_rst_press_n", press_q.size(), 0);
        check_val("hold_rst_held_n", held_n, 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_val("hold_rst_rel_n", release_q.size(), 0);
        step(1'b1, 1'b0);
        check_val("hold_rst_repress", int'(press_pulse), 1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Reset while long-held: all outputs drop, no release event afterwards.
        reset_idle();
        for (int i = 0; i < 23; i++) step(1'b1, 1'b0);
        check_val("midrst_long_n", long_q.size(), 1);
        check_val("midrst_held_pre", int'(held), 1);
        step(1'b1, 1'b1);
        check_val("midrst_outs", outs(), 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_val("midrst_rel_n", release_q.size(), 0);
        check_val("midrst_held_post", int'(held), 0);
        step(1'b1, 1'b0);
        check_val("midrst_repress", int'(press_pulse), 1);
        step(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
